ddr_rd_checker: RTL and testbench



---
 rtl/ddr_rd_checker.sv | 181 ++++++++++++++++++
 tb/tb_ddr_rd_checker.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ddr_rd_checker.sv
// ddr_rd_checker: read-back integrity checker on the user side of the DDR3
// read FIFO (clk_fifo domain). Issues FIFO reads once calibration and the
// memory read-enable allow it, compares every valid word against the
// incrementing pattern written by the data generator, and keeps per-pass and
// running error statistics.
//
// Optional feature macro: CHK_ERR_CAPTURE_EN
//   defined   - first_err_idx/first_err_data/first_err_exp capture the first
//               mismatch after reset and then freeze
//   undefined - capture registers are not built, those outputs read 0
module ddr_rd_checker #(
    parameter int unsigned       DATA_W     = 16,
    parameter logic [DATA_W-1:0] EXP_INIT   = 16'd0,
    parameter logic [DATA_W-1:0] EXP_MAX    = 16'd8191,
    parameter logic [31:0]       PASS_WORDS = 32'd8192
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              calib_done,
    input  logic              rd_mem_enable,
    input  logic              rd_valid,
    input  logic [DATA_W-1:0] rd_data,
    output logic              rd_en,
    output logic              data_correct,
    output logic [15:0]       err_cnt,
    output logic [15:0]       pass_cnt,
    output logic              pass_done,
    output logic              pass_ok,
    output logic [31:0]       first_err_idx,
    output logic [DATA_W-1:0] first_err_data,
    output logic [DATA_W-1:0] first_err_exp
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_CHECK,
        ST_END
    } state_t;

    state_t            state_q, state_d;
    logic [31:0]       wordIdx_q, wordIdx_d;
    logic [DATA_W-1:0] expWord_q, expWord_d;
    logic              passErr_q, passErr_d;
    logic              hadErr_q, hadErr_d;
    logic              checkedAny_q, checkedAny_d;
    logic [15:0]       errCnt_q, errCnt_d;
    logic [15:0]       passCnt_q, passCnt_d;
    logic              passOk_q, passOk_d;
    logic              passDone_q;
    logic              rdEn_q;
    logic              dataCorrect_q;

    logic              wordAccept;
    logic              wordMismatch;
    logic              lastWord;

    // A word is consumed in any state but IDLE, so words still in flight
    // after reads are throttled (WAIT) or during END are checked too.
    always_comb begin
        wordAccept   = rd_valid && (state_q != ST_IDLE);
        wordMismatch = wordAccept && (rd_data != expWord_q);
        lastWord     = wordAccept && (wordIdx_q == PASS_WORDS - 32'd1);
    end

    // Next-state logic; consuming the final word of a pass always lands in END.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  state_d = ST_WAIT;
            ST_WAIT:  if (calib_done && rd_mem_enable) state_d = ST_CHECK;
            ST_CHECK: if (!(calib_done && rd_mem_enable)) state_d = ST_WAIT;
            ST_END:   state_d = rd_mem_enable ? ST_CHECK : ST_WAIT;
            default:  state_d = ST_IDLE;
        endcase
        if (lastWord) begin
            state_d = ST_END;
        end
    end

    // Compare datapath: pattern stepping, pass bookkeeping and error counting.
    always_comb begin
        wordIdx_d    = wordIdx_q;
        expWord_d    = expWord_q;
        passErr_d    = passErr_q;
        hadErr_d     = hadErr_q;
        checkedAny_d = checkedAny_q;
        errCnt_d     = errCnt_q;
        passCnt_d    = passCnt_q;
        passOk_d     = passOk_q;
        if (wordAccept) begin
            checkedAny_d = 1'b1;
            expWord_d    = (expWord_q == EXP_MAX) ? EXP_INIT : expWord_q + DATA_W'(1);
            if (lastWord) begin
                // Pass result includes the final word; index and flag restart
                // so a word arriving during END counts as word 0.
                wordIdx_d = 32'd0;
                passErr_d = 1'b0;
                passCnt_d = passCnt_q + 16'd1;
                passOk_d  = !(passErr_q || wordMismatch);
            end else begin
                wordIdx_d = wordIdx_q + 32'd1;
                if (wordMismatch) begin
                    passErr_d = 1'b1;
                end
            end
            if (wordMismatch) begin
                hadErr_d = 1'b1;
                if (errCnt_q != 16'hFFFF) begin
                    errCnt_d = errCnt_q + 16'd1;
                end
            end
        end
    end

    // State and statistics registers; outputs are registered from next-state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            wordIdx_q     <= 32'd0;
            expWord_q     <= EXP_INIT;
            passErr_q     <= 1'b0;
            hadErr_q      <= 1'b0;
            checkedAny_q  <= 1'b0;
            errCnt_q      <= 16'd0;
            passCnt_q     <= 16'd0;
            passOk_q      <= 1'b0;
            passDone_q    <= 1'b0;
            rdEn_q        <= 1'b0;
            dataCorrect_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            wordIdx_q     <= wordIdx_d;
            expWord_q     <= expWord_d;
            passErr_q     <= passErr_d;
            hadErr_q      <= hadErr_d;
            checkedAny_q  <= checkedAny_d;
            errCnt_q      <= errCnt_d;
            passCnt_q     <= passCnt_d;
            passOk_q      <= passOk_d;
            passDone_q    <= (state_d == ST_END);
            rdEn_q        <= (state_d == ST_CHECK);
            dataCorrect_q <= checkedAny_d && !hadErr_d;
        end
    end

    assign rd_en        = rdEn_q;
    assign data_correct = dataCorrect_q;
    assign err_cnt      = errCnt_q;
    assign pass_cnt     = passCnt_q;
    assign pass_done    = passDone_q;
    assign pass_ok      = passOk_q;

`ifdef CHK_ERR_CAPTURE_EN
    logic [31:0]       firstErrIdx_q;
    logic [DATA_W-1:0] firstErrData_q;
    logic [DATA_W-1:0] firstErrExp_q;

    // Snapshot of the first mismatch since reset; frozen afterwards.
    always_ff @(posedge clk) begin
        if (rst) begin
            firstErrIdx_q  <= 32'd0;
            firstErrData_q <= '0;
            firstErrExp_q  <= '0;
        end else if (wordMismatch && !hadErr_q) begin
            firstErrIdx_q  <= wordIdx_q;
            firstErrData_q <= rd_data;
            firstErrExp_q  <= expWord_q;
        end
    end

    assign first_err_idx  = firstErrIdx_q;
    assign first_err_data = firstErrData_q;
    assign first_err_exp  = firstErrExp_q;
`else
    assign first_err_idx  = 32'd0;
    assign first_err_data = '0;
    assign first_err_exp  = '0;
`endif

endmodule

// File: tb/tb_ddr_rd_checker.sv
// Directed testbench for ddr_rd_checker. Instance A uses default parameters
// for full 8192-word passes, instance B uses a 4-value pattern with 6-word
// passes, instance C drives a long mismatching stream for saturation.
module tb_ddr_rd_checker;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int totalChecks = 0;
    int passedChecks = 0;

    // Instance A signals
    logic        rstA = 1'b1, calA = 1'b1, memA = 1'b1, rdValidA = 1'b0;
    logic [15:0] rdDataA = 16'd0;
    logic        rdEnA, dcA, passDoneA, passOkA;
    logic [15:0] errCntA, passCntA, feDataA, feExpA;
    logic [31:0] feIdxA;

    // Instance B signals
    logic        rstB = 1'b1, rdValidB = 1'b0;
    logic [15:0] rdDataB = 16'd0;
    logic        rdEnB, dcB, passDoneB, passOkB;
    logic [15:0] errCntB, passCntB, feDataB, feExpB;
    logic [31:0] feIdxB;

    // Instance C signals
    logic        rstC = 1'b1, rdValidC = 1'b0;
    logic [15:0] rdDataC = 16'd0;
    logic        rdEnC, dcC, passDoneC, passOkC;
    logic [15:0] errCntC, passCntC, feDataC, feExpC;
    logic [31:0] feIdxC;

    ddr_rd_checker dutA (
        .clk(clk), .rst(rstA), .calib_done(calA), .rd_mem_enable(memA),
        .rd_valid(rdValidA), .rd_data(rdDataA), .rd_en(rdEnA),
        .data_correct(dcA), .err_cnt(errCntA), .pass_cnt(passCntA),
        .pass_done(passDoneA), .pass_ok(passOkA), .first_err_idx(feIdxA),
        .first_err_data(feDataA), .first_err_exp(feExpA)
    );

    ddr_rd_checker #(
        .DATA_W(16), .EXP_INIT(16'd0), .EXP_MAX(16'd3), .PASS_WORDS(32'd6)
    ) dutB (
        .clk(clk), .rst(rstB), .calib_done(1'b1), .rd_mem_enable(1'b1),
        .rd_valid(rdValidB), .rd_data(rdDataB), .rd_en(rdEnB),
        .data_correct(dcB), .err_cnt(errCntB), .pass_cnt(passCntB),
        .pass_done(passDoneB), .pass_ok(passOkB), .first_err_idx(feIdxB),
        .first_err_data(feDataB), .first_err_exp(feExpB)
    );

    ddr_rd_checker dutC (
        .clk(clk), .rst(rstC), .calib_done(1'b1), .rd_mem_enable(1'b1),
        .rd_valid(rdValidC), .rd_data(rdDataC), .rd_en(rdEnC),
        .data_correct(dcC), .err_cnt(errCntC), .pass_cnt(passCntC),
        .pass_done(passDoneC), .pass_ok(passOkC), .first_err_idx(feIdxC),
        .first_err_data(feDataC), .first_err_exp(feExpC)
    );

    // Pass-done and rd_en-low monitors, enabled over selected windows
    logic monA = 1'b0, monB = 1'b0;
    int   pulsesA = 0, lowsA = 0, pulsesB = 0, okPulsesB = 0;

    always @(negedge clk) begin
        if (monA) begin
            if (passDoneA) pulsesA++;
            if (!rdEnA) lowsA++;
        end
        if (monB && passDoneB) begin
            pulsesB++;
            if (passOkB) okPulsesB++;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        totalChecks++;
        if (observed !== expected)
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        else
            passedChecks++;
    endtask

    // Streams n words into A while rd_en is high; word k carries
    // (startVal+k) mod 8192, except index badIdx which carries badVal.
    // Returns one negedge after the last word, with rd_valid cleared.
    task automatic applyStimulus(input int n, input int startVal, input int badIdx,
                                 input logic [15:0] badVal);
        int k = 0;
        int cyc = 0;
        while (k < n && cyc < n + 1000) begin
            @(negedge clk);
            cyc++;
            if (rdEnA) begin
                rdValidA = 1'b1;
                rdDataA  = (k == badIdx) ? badVal : 16'((startVal + k) % 8192);
                k++;
            end else begin
                rdValidA = 1'b0;
            end
        end
        @(negedge clk);
        rdValidA = 1'b0;
        checkOutput("feedWordsA", k, n);
    endtask

    task automatic waitRdEnA();
        for (int i = 0; i < 20 && !rdEnA; i++) @(negedge clk);
        checkOutput("waitRdEnA", {31'd0, rdEnA}, 32'd1);
    endtask

    task automatic resetA();
        rstA = 1'b1;
        rdValidA = 1'b0;
        repeat (2) @(negedge clk);
        rstA = 1'b0;
        waitRdEnA();
    endtask

    task automatic checkResetA(input string pfx);
        checkOutput({pfx, "RdEn"}, {31'd0, rdEnA}, 32'd0);
        checkOutput({pfx, "DataCorrect"}, {31'd0, dcA}, 32'd0);
        checkOutput({pfx, "ErrCnt"}, {16'd0, errCntA}, 32'd0);
        checkOutput({pfx, "PassCnt"}, {16'd0, passCntA}, 32'd0);
        checkOutput({pfx, "PassDone"}, {31'd0, passDoneA}, 32'd0);
        checkOutput({pfx, "PassOk"}, {31'd0, passOkA}, 32'd0);
        checkOutput({pfx, "FirstErrIdx"}, feIdxA, 32'd0);
        checkOutput({pfx, "FirstErrData"}, {16'd0, feDataA}, 32'd0);
        checkOutput({pfx, "FirstErrExp"}, {16'd0, feExpA}, 32'd0);
    endtask

    initial begin
        fork
            // Instance A: full-size passes, error capture, reset, throttling
            begin
                repeat (2) @(negedge clk);
                checkResetA("rst0");
                rstA = 1'b0;
                waitRdEnA();

                // Clean pass 0..8191
                monA = 1'b1;
                applyStimulus(8192, 0, -1, 16'd0);
                repeat (3) @(negedge clk);
                monA = 1'b0;
                checkOutput("cleanPulses", pulsesA, 1);
                checkOutput("cleanRdEnLow", lowsA, 1);
                checkOutput("cleanPassCnt", {16'd0, passCntA}, 32'd1);
                checkOutput("cleanPassOk", {31'd0, passOkA}, 32'd1);
                checkOutput("cleanErrCnt", {16'd0, errCntA}, 32'd0);
                checkOutput("cleanDataCorrect", {31'd0, dcA}, 32'd1);

                // Continue the sequence with a bad word, then reset mid-pass
                applyStimulus(4000, 0, 10, 16'hBEEF);
                checkOutput("midErrCnt", {16'd0, errCntA}, 32'd1);
                checkOutput("midDataCorrect", {31'd0, dcA}, 32'd0);
`ifdef CHK_ERR_CAPTURE_EN
                checkOutput("midFirstErrIdx", feIdxA, 32'd10);
`else
                checkOutput("midFirstErrIdx", feIdxA, 32'd0);
`endif
                rstA = 1'b1;
                rdValidA = 1'b1;
                rdDataA = 16'd4000;
                @(negedge clk);
                checkResetA("rstMid");
                rdValidA = 1'b0;
                @(negedge clk);
                rstA = 1'b0;
                waitRdEnA();

                // Pass with word 100 corrupted
                resetA();
                applyStimulus(8192, 0, 100, 16'hDEAD);
                checkOutput("badPassDone", {31'd0, passDoneA}, 32'd1);
                checkOutput("badErrCnt", {16'd0, errCntA}, 32'd1);
                checkOutput("badPassOk", {31'd0, passOkA}, 32'd0);
                checkOutput("badDataCorrect", {31'd0, dcA}, 32'd0);
`ifdef CHK_ERR_CAPTURE_EN
                checkOutput("badFirstErrIdx", feIdxA, 32'd100);
                checkOutput("badFirstErrData", {16'd0, feDataA}, 32'h0000DEAD);
                checkOutput("badFirstErrExp", {16'd0, feExpA}, 32'd100);
`else
                checkOutput("badFirstErrIdx", feIdxA, 32'd0);
                checkOutput("badFirstErrData", {16'd0, feDataA}, 32'd0);
                checkOutput("badFirstErrExp", {16'd0, feExpA}, 32'd0);
`endif

                // rd_mem_enable dropped for 10 cycles at word 50
                resetA();
                applyStimulus(50, 0, -1, 16'd0);
                memA = 1'b0;
                for (int i = 0; i < 10; i++) begin
                    @(negedge clk);
                    checkOutput("dropRdEn", {31'd0, rdEnA}, 32'd0);
                end
                memA = 1'b1;
                applyStimulus(8142, 50, -1, 16'd0);
                checkOutput("dropPassDone", {31'd0, passDoneA}, 32'd1);
                checkOutput("dropPassCnt", {16'd0, passCntA}, 32'd1);
                checkOutput("dropErrCnt", {16'd0, errCntA}, 32'd0);
                checkOutput("dropDataCorrect", {31'd0, dcA}, 32'd1);
            end

            // Instance B: EXP_MAX=3, PASS_WORDS=6, two clean passes
            begin
                repeat (2) @(negedge clk);
                rstB = 1'b0;
                for (int i = 0; i < 20 && !rdEnB; i++) @(negedge clk);
                checkOutput("waitRdEnB", {31'd0, rdEnB}, 32'd1);
                monB = 1'b1;
                begin
                    int k = 0;
                    int cyc = 0;
                    while (k < 12 && cyc < 100) begin
                        @(negedge clk);
                        cyc++;
                        if (rdEnB) begin
                            rdValidB = 1'b1;
                            rdDataB  = 16'(k % 4);
                            k++;
                        end else begin
                            rdValidB = 1'b0;
                        end
                    end
                    @(negedge clk);
                    rdValidB = 1'b0;
                    checkOutput("smallWords", k, 12);
                end
                @(negedge clk);
                monB = 1'b0;
                checkOutput("smallPulses", pulsesB, 2);
                checkOutput("smallOkPulses", okPulsesB, 2);
                checkOutput("smallPassCnt", {16'd0, passCntB}, 32'd2);
                checkOutput("smallErrCnt", {16'd0, errCntB}, 32'd0);
                checkOutput("smallDataCorrect", {31'd0, dcB}, 32'd1);
            end

            // Instance C: 66000 mismatching words saturate err_cnt
            begin
                repeat (2) @(negedge clk);
                rstC = 1'b0;
                begin
                    int k = 0;
                    int cyc = 0;
                    while (k < 66000 && cyc < 67000) begin
                        @(negedge clk);
                        cyc++;
                        if (rdEnC) begin
                            rdValidC = 1'b1;
                            rdDataC  = 16'hFFFF;
                            k++;
                        end else begin
                            rdValidC = 1'b0;
                        end
                    end
                    @(negedge clk);
                    rdValidC = 1'b0;
                    checkOutput("satWords", k, 66000);
                end
                checkOutput("satErrCnt", {16'd0, errCntC}, 32'h0000FFFF);
                checkOutput("satDataCorrect", {31'd0, dcC}, 32'd0);
            end
        join
        $display("%0d/%0d checks passed", passedChecks, totalChecks);
        $finish;
    end

endmodule
